// File: rtl/gmii_pkg.sv
// Shared types, constants and CRC helper for the GMII transmit path.
// Optional FCS generation is enabled with GMII_TX_CRC_EN.
package gmii_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_FCS,
    S_IFG
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam int          PREAMBLE_LEN  = 7;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;

  // Reflected CRC-32, one byte per call
  function automatic logic [31:0] crc32_byte(
    input logic [31:0] crc,
    input logic [7:0]  data
  );
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/gmii_crc32.sv
// Running CRC-32 over the frame data bytes.
// Instantiated only when GMII_TX_CRC_EN is defined.
module gmii_crc32
  import gmii_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 32'hFFFF_FFFF;
    end else if (init) begin
      crc <= 32'hFFFF_FFFF;
    end else if (en) begin
      crc <= crc32_byte(crc, data);
    end
  end

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Round-robin GMII TX arbiter with preamble/SFD, IFG and underrun flagging.
// Define GMII_TX_CRC_EN to append a generated FCS to each frame.
module gmii_tx_arbiter
  import gmii_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int IFG_CYCLES = 12
) (
  input  logic                 gmii_tx_clk,
  input  logic                 rst_n,
  input  logic                 tx_enable,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           gmii_txd,
  output logic                 gmii_tx_en,
  output logic                 gmii_tx_er,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int IFG_W = $clog2(IFG_CYCLES + 1);

  state_t           state, nxt;
  logic [2:0]       pre_cnt;
  logic [IFG_W-1:0] ifg_cnt;
  logic [2:0]       ptr;
  logic             cur_valid, cur_last;
  logic [7:0]       cur_data;
  logic             found, ifg_last, decide, take;
  logic [2:0]       pick;
  logic [7:0]       d_txd;
  logic             d_en, d_er, d_done;

  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == 3'(i)) begin
        cur_valid = req_valid[i];
        cur_last  = req_last[i];
        cur_data  = req_data[8*i +: 8];
      end
    end
  end

  // Search starts one past the pointer and wraps
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req_valid[j] &&
            ((int'(ptr) + k == j) ||
             (int'(ptr) + k == j + NUM_REQ))) begin
          found = 1'b1;
          pick  = 3'(j);
        end
      end
    end
  end

  assign ifg_last = (ifg_cnt == IFG_W'(IFG_CYCLES - 1));
  assign decide   = (state == S_IDLE) ||
                    ((state == S_IFG) && ifg_last);
  assign take     = decide && tx_enable && found;
  assign busy     = (state != S_IDLE);

  always_comb begin
    req_ready = '0;
    if (state == S_DATA) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (grant_id == 3'(i));
      end
    end
  end

`ifdef GMII_TX_CRC_EN
  logic [31:0] crc;
  logic [1:0]  fcs_cnt;
  logic        underrun;
  logic [7:0]  fcs_byte;

  gmii_crc32 u_crc (
    .clk   (gmii_tx_clk),
    .rst_n (rst_n),
    .init  (state == S_SFD),
    .en    ((state == S_DATA) && cur_valid),
    .data  (cur_data),
    .crc   (crc)
  );

  assign fcs_byte = 8'(~crc >> {fcs_cnt, 3'b000});

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      fcs_cnt  <= 2'd0;
      underrun <= 1'b0;
    end else begin
      fcs_cnt <= (state == S_FCS) ? fcs_cnt + 2'd1 : 2'd0;
      if (state == S_SFD) begin
        underrun <= 1'b0;
      end else if ((state == S_DATA) && !cur_valid) begin
        underrun <= 1'b1;
      end
    end
  end
`endif

  always_comb begin
    nxt    = state;
    d_txd  = 8'h00;
    d_en   = 1'b0;
    d_er   = 1'b0;
    d_done = 1'b0;
    unique case (state)
      S_IDLE: if (take) nxt = S_PRE;
      S_PRE: begin
        d_txd = PREAMBLE_BYTE;
        d_en  = 1'b1;
        if (pre_cnt == 3'(PREAMBLE_LEN - 1)) nxt = S_SFD;
      end
      S_SFD: begin
        d_txd = SFD_BYTE;
        d_en  = 1'b1;
        nxt   = S_DATA;
      end
      S_DATA: begin
        d_en = 1'b1;
        if (cur_valid) begin
          d_txd = cur_data;
          if (cur_last) begin
`ifdef GMII_TX_CRC_EN
            nxt = S_FCS;
`else
            nxt    = S_IFG;
            d_done = 1'b1;
`endif
          end
        end else begin
          d_er = 1'b1;
        end
      end
      S_FCS: begin
`ifdef GMII_TX_CRC_EN
        d_txd = fcs_byte;
        d_en  = 1'b1;
        d_er  = underrun;
        if (fcs_cnt == 2'd3) begin
          nxt    = S_IFG;
          d_done = 1'b1;
        end
`else
        nxt = S_IDLE;
`endif
      end
      S_IFG: begin
        if (ifg_last) nxt = take ? S_PRE : S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pre_cnt    <= 3'd0;
      ifg_cnt    <= '0;
      ptr        <= 3'(NUM_REQ - 1);
      grant_id   <= 3'd0;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      gmii_tx_er <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= nxt;
      pre_cnt    <= (state == S_PRE) ? pre_cnt + 3'd1 : 3'd0;
      ifg_cnt    <= (state == S_IFG) ? ifg_cnt + 1'b1 : '0;
      if (take) begin
        ptr      <= pick;
        grant_id <= pick;
      end
      gmii_txd   <= d_txd;
      gmii_tx_en <= d_en;
      gmii_tx_er <= d_er;
      frame_done <= d_done;
    end
  end

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed self-checking bench for gmii_tx_arbiter.
// Follows GMII_TX_CRC_EN to expect FCS bytes when it is defined.
module tb_gmii_tx_arbiter;

  localparam int IFG = 12;
`ifdef GMII_TX_CRC_EN
  localparam int FCS_LEN = 4;
`else
  localparam int FCS_LEN = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_enable = 1'b0;
  logic [1:0]  req_valid, req_last, req_ready;
  logic [15:0] req_data;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en, gmii_tx_er;
  logic [2:0]  grant_id;
  logic        busy, frame_done;

  gmii_tx_arbiter #(.NUM_REQ(2), .IFG_CYCLES(IFG)) dut (
    .gmii_tx_clk (clk),
    .rst_n       (rst_n),
    .tx_enable   (tx_enable),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .gmii_txd    (gmii_txd),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_tx_er  (gmii_tx_er),
    .grant_id    (grant_id),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #4 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [2][64];
  logic       mlast [2][64];
  int len [2], pos [2], stall_at [2], stall_len [2], stalled [2];

  logic [7:0] l_txd [256];
  logic       l_en [256], l_er [256], l_done [256], l_busy [256];
  logic [2:0] l_gid [256];
  logic [1:0] l_rdy [256];
  int log_n;

  task automatic reset_src();
    for (int s = 0; s < 2; s++) begin
      len[s] = 0; pos[s] = 0; stalled[s] = 0;
      stall_at[s] = -1; stall_len[s] = 0;
    end
    req_valid = '0; req_last = '0; req_data = '0;
  endtask

  task automatic append(input int s, input logic [7:0] base,
                        input int n);
    for (int b = 0; b < n; b++) begin
      mem[s][len[s]]   = base + 8'(b);
      mlast[s][len[s]] = (b == n - 1);
      len[s]++;
    end
  endtask

  task automatic drive_srcs();
    for (int s = 0; s < 2; s++) begin
      if (pos[s] < len[s] &&
          !(pos[s] == stall_at[s] && stalled[s] < stall_len[s])) begin
        req_valid[s]        = 1'b1;
        req_data[8*s +: 8]  = mem[s][pos[s]];
        req_last[s]         = mlast[s][pos[s]];
      end else begin
        req_valid[s]        = 1'b0;
        req_data[8*s +: 8]  = 8'h00;
        req_last[s]         = 1'b0;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    logic [1:0] rdy;
    repeat (n) begin
      drive_srcs();
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      for (int s = 0; s < 2; s++) begin
        if (req_valid[s] && rdy[s]) pos[s]++;
        else if (pos[s] < len[s] && pos[s] == stall_at[s] &&
                 stalled[s] < stall_len[s]) stalled[s]++;
      end
      #1;
      if (log_n < 256) begin
        l_txd[log_n]  = gmii_txd;
        l_en[log_n]   = gmii_tx_en;
        l_er[log_n]   = gmii_tx_er;
        l_done[log_n] = frame_done;
        l_busy[log_n] = busy;
        l_gid[log_n]  = grant_id;
        l_rdy[log_n]  = rdy;
        log_n++;
      end
    end
  endtask

  task automatic find_burst(input int from, output int st,
                            output int ln);
    st = -1;
    ln = 0;
    for (int i = from; i < log_n; i++) begin
      if (l_en[i]) begin
        st = i;
        break;
      end
    end
    if (st >= 0) begin
      while (st + ln < log_n && l_en[st + ln]) ln++;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tx_enable = 1'b0;
    reset_src();
    log_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (gmii_tx_en !== 1'b0 || gmii_tx_er !== 1'b0) begin
      errors++;
      $display("FAIL reset_en_er: got %b%b want 00",
               gmii_tx_en, gmii_tx_er);
    end
    checks++;
    if (gmii_txd !== 8'h00 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_txd_done: got %h/%b want 00/0",
               gmii_txd, frame_done);
    end
    checks++;
    if (busy !== 1'b0 || grant_id !== 3'd0 || req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctrl: busy %b gid %0d rdy %b want 0 0 00",
               busy, grant_id, req_ready);
    end
  endtask

  task automatic test_single_frame();
    int st, ln, nd, ner, nboth;
    logic [7:0] exp;
    apply_reset();
    tx_enable = 1'b1;
    append(0, 8'hA0, 10);
    run_cycles(45);
    find_burst(0, st, ln);
    checks++;
    if (st !== 1) begin
      errors++;
      $display("FAIL single_start: got %0d want 1", st);
    end
    checks++;
    if (ln !== 18 + FCS_LEN) begin
      errors++;
      $display("FAIL single_len: got %0d want %0d", ln, 18 + FCS_LEN);
    end
    if (st >= 0) begin
      for (int i = 0; i < 18; i++) begin
        exp = (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : 8'hA0 + 8'(i - 8);
        checks++;
        if (l_txd[st + i] !== exp) begin
          errors++;
          $display("FAIL single_byte%0d: got %h want %h",
                   i, l_txd[st + i], exp);
        end
      end
      checks++;
      if (l_done[st + ln - 1] !== 1'b1) begin
        errors++;
        $display("FAIL single_done_pos: got %b want 1",
                 l_done[st + ln - 1]);
      end
      checks++;
      if (l_gid[st + 8] !== 3'd0) begin
        errors++;
        $display("FAIL single_gid: got %0d want 0", l_gid[st + 8]);
      end
    end
    nd = 0; ner = 0; nboth = 0;
    for (int i = 0; i < log_n; i++) begin
      nd += int'(l_done[i]);
      ner += int'(l_er[i]);
      nboth += int'(l_rdy[i] == 2'b11);
    end
    checks++;
    if (nd !== 1) begin
      errors++;
      $display("FAIL single_done_cnt: got %0d want 1", nd);
    end
    checks++;
    if (ner !== 0 || nboth !== 0) begin
      errors++;
      $display("FAIL single_er_rdy: er %0d both %0d want 0 0",
               ner, nboth);
    end
  endtask

  task automatic test_round_robin();
    int st, ln, from, pend;
    logic [7:0] first [4];
    logic [2:0] gid [4];
    first = '{8'h00, 8'h40, 8'h10, 8'h50};
    gid   = '{3'd0, 3'd1, 3'd0, 3'd1};
    apply_reset();
    tx_enable = 1'b1;
    append(0, 8'h00, 4);
    append(0, 8'h10, 4);
    append(1, 8'h40, 4);
    append(1, 8'h50, 4);
    run_cycles(150);
    from = 0;
    pend = -1;
    for (int f = 0; f < 4; f++) begin
      find_burst(from, st, ln);
      checks++;
      if (st < 0 || ln !== 12 + FCS_LEN) begin
        errors++;
        $display("FAIL rr_len%0d: start %0d len %0d want len %0d",
                 f, st, ln, 12 + FCS_LEN);
        break;
      end
      if (pend >= 0) begin
        checks++;
        if (st - pend !== IFG) begin
          errors++;
          $display("FAIL rr_gap%0d: got %0d want %0d",
                   f, st - pend, IFG);
        end
      end
      checks++;
      if (l_txd[st + 8] !== first[f] || l_gid[st + 8] !== gid[f]) begin
        errors++;
        $display("FAIL rr_src%0d: byte %h gid %0d want %h %0d",
                 f, l_txd[st + 8], l_gid[st + 8], first[f], gid[f]);
      end
      pend = st + ln;
      from = st + ln;
    end
  endtask

  task automatic test_underrun();
    int st, ln;
    logic [7:0] exp;
    logic       eer;
    apply_reset();
    tx_enable = 1'b1;
    append(1, 8'h60, 8);
    stall_at[1] = 4;
    stall_len[1] = 3;
    run_cycles(60);
    find_burst(0, st, ln);
    checks++;
    if (st < 0 || ln !== 19 + FCS_LEN) begin
      errors++;
      $display("FAIL underrun_len: start %0d len %0d want len %0d",
               st, ln, 19 + FCS_LEN);
    end else begin
      for (int i = 8; i < 19; i++) begin
        if (i < 12) begin exp = 8'h60 + 8'(i - 8); eer = 1'b0; end
        else if (i < 15) begin exp = 8'h00; eer = 1'b1; end
        else begin exp = 8'h64 + 8'(i - 15); eer = 1'b0; end
        checks++;
        if (l_txd[st + i] !== exp || l_er[st + i] !== eer) begin
          errors++;
          $display("FAIL underrun_b%0d: got %h/%b want %h/%b",
                   i, l_txd[st + i], l_er[st + i], exp, eer);
        end
      end
      for (int i = 19; i < ln; i++) begin
        checks++;
        if (l_er[st + i] !== 1'b1) begin
          errors++;
          $display("FAIL underrun_fcs_er%0d: got %b want 1",
                   i, l_er[st + i]);
        end
      end
      checks++;
      if (l_done[st + ln - 1] !== 1'b1 || l_gid[st] !== 3'd1) begin
        errors++;
        $display("FAIL underrun_end: done %b gid %0d want 1 1",
                 l_done[st + ln - 1], l_gid[st]);
      end
    end
  endtask

`ifdef GMII_TX_CRC_EN
  task automatic test_crc();
    int st, ln;
    string msg;
    logic [7:0] fcs [4];
    fcs = '{8'h26, 8'h39, 8'hF4, 8'hCB};
    msg = "123456789";
    apply_reset();
    tx_enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      mem[0][i]   = msg[i];
      mlast[0][i] = (i == 8);
    end
    len[0] = 9;
    run_cycles(40);
    find_burst(0, st, ln);
    checks++;
    if (st < 0 || ln !== 21) begin
      errors++;
      $display("FAIL crc_len: start %0d len %0d want 21", st, ln);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (l_txd[st + 17 + i] !== fcs[i]) begin
          errors++;
          $display("FAIL crc_fcs%0d: got %h want %h",
                   i, l_txd[st + 17 + i], fcs[i]);
        end
      end
    end
  endtask
`endif

  task automatic test_tx_enable();
    int st, ln, st2, ln2;
    apply_reset();
    tx_enable = 1'b1;
    append(0, 8'h20, 4);
    run_cycles(5);
    tx_enable = 1'b0;
    append(1, 8'h40, 4);
    run_cycles(60);
    find_burst(0, st, ln);
    checks++;
    if (st !== 1 || ln !== 12 + FCS_LEN) begin
      errors++;
      $display("FAIL txen_first: start %0d len %0d want 1 %0d",
               st, ln, 12 + FCS_LEN);
    end
    find_burst(st + ln, st2, ln2);
    checks++;
    if (st2 !== -1 || l_busy[log_n - 1] !== 1'b0) begin
      errors++;
      $display("FAIL txen_hold: start %0d busy %b want -1 0",
               st2, l_busy[log_n - 1]);
    end
    tx_enable = 1'b1;
    run_cycles(40);
    find_burst(st + ln, st2, ln2);
    checks++;
    if (st2 < 0 || l_txd[st2 + 8] !== 8'h40 ||
        l_gid[st2 + 8] !== 3'd1) begin
      errors++;
      $display("FAIL txen_resume: start %0d gid %0d want src 1",
               st2, st2 < 0 ? 3'd7 : l_gid[st2 + 8]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int st, ln;
    apply_reset();
    tx_enable = 1'b1;
    append(0, 8'hA0, 10);
    run_cycles(12);
    checks++;
    if (gmii_tx_en !== 1'b1 || req_ready !== 2'b01) begin
      errors++;
      $display("FAIL midrst_pre: en %b rdy %b want 1 01",
               gmii_tx_en, req_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (gmii_tx_en !== 1'b0 || req_ready !== 2'b00 ||
        gmii_tx_er !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_now: en %b rdy %b er %b busy %b want 0",
               gmii_tx_en, req_ready, gmii_tx_er, busy);
    end
    reset_src();
    @(posedge clk);
    #1 rst_n = 1'b1;
    log_n = 0;
    append(1, 8'h40, 4);
    append(0, 8'h00, 4);
    run_cycles(30);
    find_burst(0, st, ln);
    checks++;
    if (st < 0 || l_txd[st + 8] !== 8'h00 || l_gid[st + 8] !== 3'd0) begin
      errors++;
      $display("FAIL midrst_grant: start %0d want src0 first", st);
    end
  endtask

  initial begin
    reset_src();
    log_n = 0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_underrun();
`ifdef GMII_TX_CRC_EN
    test_crc();
`endif
    test_tx_enable();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
